// File: rtl/gcd_seq_unit.sv
// gcd_seq_unit
//   Sequential GCD engine using repeated subtraction. Owns the control side
//   of the datapath and drives the select/load strobes for the A/B operand
//   muxes and registers.
//
// Optional feature macro: GCD_ITER_COUNT_EN
//   When defined, adds output iter_count: the number of subtraction cycles
//   taken by the most recent operation.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair a_in/b_in is valid
//   in_ready   unit can accept an operand pair (IDLE)
//   a_in,b_in  operands, sampled only on the accept edge
//   out_valid  gcd_out is valid (DONE)
//   out_ready  consumer accepts gcd_out
//   gcd_out    result, held stable while out_valid && !out_ready
//   busy       high in CALC or DONE
//   iter_count subtraction count (GCD_ITER_COUNT_EN only)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for an operand pair, in_ready high
// CALC  | one compare/subtract decision per cycle
// DONE  | result presented, waiting for out_ready

module gcd_seq_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic             busy
`ifdef GCD_ITER_COUNT_EN
  ,
  output logic [WIDTH-1:0] iter_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [WIDTH-1:0] a_mux, b_mux;
  logic             sel_ext;
  logic             load_a, load_b, load_r;
  logic             clr_iter, inc_iter;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_ext  = 1'b0;
    load_a   = 1'b0;
    load_b   = 1'b0;
    load_r   = 1'b0;
    clr_iter = 1'b0;
    inc_iter = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sel_ext  = 1'b1;
          load_a   = 1'b1;
          load_b   = 1'b1;
          clr_iter = 1'b1;
          state_d  = CALC;
        end
      end
      CALC: begin
        // Zero operand or equal operands both finish with A|B as the result.
        if ((a_q == '0) || (b_q == '0) || (a_q == b_q)) begin
          load_r  = 1'b1;
          state_d = DONE;
        end else if (a_q > b_q) begin
          load_a   = 1'b1;
          inc_iter = 1'b1;
        end else begin
          load_b   = 1'b1;
          inc_iter = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Feedback paths only ever subtract the smaller from the larger because
  // the controller loads A only when A>B and B only when B>A.
  assign a_mux = sel_ext ? a_in : (a_q - b_q);
  assign b_mux = sel_ext ? b_in : (b_q - a_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      if (load_a) a_q <= a_mux;
      if (load_b) b_q <= b_mux;
      if (load_r) result_q <= a_q | b_q;
    end
  end

`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH-1:0] iter_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_q <= '0;
    end else if (clr_iter) begin
      iter_q <= '0;
    end else if (inc_iter) begin
      iter_q <= iter_q + WIDTH'(1);
    end
  end

  assign iter_count = iter_q;
`else
  logic unused_iter;
  assign unused_iter = clr_iter ^ inc_iter;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign gcd_out   = result_q;

endmodule
